// File: rtl/alu_rs_scheduler_pkg.sv
// rtl/alu_rs_scheduler_pkg.sv - shared widths, opcode constants and helpers for the ALU reservation station
package alu_rs_scheduler_pkg;

    localparam int DATA_W    = 32;
    localparam int OP_W      = 7;
    localparam int DEF_TAG_W = 5;

    localparam logic [OP_W-1:0] add_type  = 7'd1;
    localparam logic [OP_W-1:0] sub_type  = 7'd2;
    localparam logic [OP_W-1:0] addi_type = 7'd3;
    localparam logic [OP_W-1:0] xor_type  = 7'd4;
    localparam logic [OP_W-1:0] slli_type = 7'd5;
    localparam logic [OP_W-1:0] beq_type  = 7'd6;
    localparam logic [OP_W-1:0] jal_type  = 7'd7;

    function automatic logic entry_ready(input logic busy, input logic qj_wait, input logic qk_wait);
        return busy && !qj_wait && !qk_wait;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_rs_select.sv
// rtl/alu_rs_scheduler_rs_select.sv - combinational ready-entry picker (age matrix used when ALU_RS_AGE_PRIORITY_EN)
module rs_select #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]              ready,
`ifdef ALU_RS_AGE_PRIORITY_EN
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] older,
`endif
    output logic                            sel_valid,
    output logic [IDX_W-1:0]                sel_idx
);

`ifdef ALU_RS_AGE_PRIORITY_EN
    logic win;

    // An entry wins when it is ready and older than every other ready entry
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        win       = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            win = ready[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && !older[i][j]) begin
                    win = 1'b0;
                end
            end
            if (win) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Lowest-index ready entry wins
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station and issue scheduler (ALU_RS_AGE_PRIORITY_EN selects oldest-first issue)
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              dispatch_valid,
    input  logic [OP_W-1:0]   dispatch_opcode,
    input  logic [DATA_W-1:0] dispatch_pc,
    input  logic [DATA_W-1:0] dispatch_imm,
    input  logic [DATA_W-1:0] dispatch_vj,
    input  logic [DATA_W-1:0] dispatch_vk,
    input  logic              dispatch_qj_wait,
    input  logic              dispatch_qk_wait,
    input  logic [TAG_W-1:0]  dispatch_qj,
    input  logic [TAG_W-1:0]  dispatch_qk,
    input  logic [TAG_W-1:0]  dispatch_dest,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_pc,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [DATA_W-1:0] alu_imm,
    output logic [TAG_W-1:0]  alu_calc_name
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_wait;
        logic              qk_wait;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  dest;
    } rs_entry_t;

    rs_entry_t          ent [RS_SIZE];
    rs_entry_t          new_ent;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic               alloc;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;

    // Busy and ready vectors come from registered state only
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = entry_ready(ent[i].busy, ent[i].qj_wait, ent[i].qk_wait);
        end
    end

    assign rs_full = &busy_vec;
    assign alloc   = dispatch_valid && !rs_full;

    // Free-slot finder: lowest-index idle entry
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry, with operands forwarded from a same-cycle broadcast
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = dispatch_opcode;
        new_ent.pc      = dispatch_pc;
        new_ent.imm     = dispatch_imm;
        new_ent.vj      = dispatch_vj;
        new_ent.vk      = dispatch_vk;
        new_ent.qj_wait = dispatch_qj_wait;
        new_ent.qk_wait = dispatch_qk_wait;
        new_ent.qj      = dispatch_qj;
        new_ent.qk      = dispatch_qk;
        new_ent.dest    = dispatch_dest;
        if (cdb_valid && dispatch_qj_wait && dispatch_qj == cdb_tag) begin
            new_ent.qj_wait = 1'b0;
            new_ent.vj      = cdb_value;
        end
        if (cdb_valid && dispatch_qk_wait && dispatch_qk == cdb_tag) begin
            new_ent.qk_wait = 1'b0;
            new_ent.vk      = cdb_value;
        end
    end

`ifdef ALU_RS_AGE_PRIORITY_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;

    // older[i][j] set means entry i was allocated before entry j
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            older <= '0;
        end else if (!flush && rdy_in) begin
            if (sel_valid) begin
                older[sel_idx] <= '0;
            end
            if (alloc) begin
                older[free_idx] <= '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (IDX_W'(j) != free_idx) begin
                        older[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

    rs_select #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_rs_select (
        .ready     (ready_vec),
`ifdef ALU_RS_AGE_PRIORITY_EN
        .older     (older),
`endif
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    // Entry array and ALU output registers: reset > flush > stall > issue/dispatch/wake-up
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            alu_valid     <= 1'b0;
            alu_opcode    <= '0;
            alu_pc        <= '0;
            alu_rs1       <= '0;
            alu_rs2       <= '0;
            alu_imm       <= '0;
            alu_calc_name <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i].busy <= 1'b0;
            end
            alu_valid <= 1'b0;
        end else if (!rdy_in) begin
            alu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy && cdb_valid) begin
                    if (ent[i].qj_wait && ent[i].qj == cdb_tag) begin
                        ent[i].qj_wait <= 1'b0;
                        ent[i].vj      <= cdb_value;
                    end
                    if (ent[i].qk_wait && ent[i].qk == cdb_tag) begin
                        ent[i].qk_wait <= 1'b0;
                        ent[i].vk      <= cdb_value;
                    end
                end
            end
            alu_valid <= sel_valid;
            if (sel_valid) begin
                alu_opcode         <= ent[sel_idx].op;
                alu_pc             <= ent[sel_idx].pc;
                alu_rs1            <= ent[sel_idx].vj;
                alu_rs2            <= ent[sel_idx].vk;
                alu_imm            <= ent[sel_idx].imm;
                alu_calc_name      <= ent[sel_idx].dest;
                ent[sel_idx].busy  <= 1'b0;
            end
            if (alloc) begin
                ent[free_idx] <= new_ent;
            end
        end
    end

endmodule
